// File: rtl/ex_hazard_ctrl_if.sv
// Signal bundle between the execute-stage pipeline datapath and its hazard controller.
interface ex_hazard_ctrl_if #(
    parameter int REG_BITS = 3,
    parameter int CNT_W    = 16
);
    logic [REG_BITS-1:0] id_rs1, id_rs2, id_rs3;
    logic                id_use_rs1, id_use_rs2, id_use_rs3;
    logic [REG_BITS-1:0] ex_rs1, ex_rs2, ex_rs3;
    logic [REG_BITS-1:0] ex_rd;
    logic                ex_regwrite, ex_memread;
    logic [REG_BITS-1:0] mem_rd;
    logic                mem_regwrite, mem_memread;
    logic [REG_BITS-1:0] wb_rd;
    logic                wb_regwrite;
    logic                br_taken, mem_busy, clr_cnt;
    logic [1:0]          fwd1_sel, fwd2_sel;
    logic                fwd3_sel;
    logic                pc_write, ifid_write, idex_write, exmem_write;
    logic                ifid_flush, idex_bubble;
    logic [CNT_W-1:0]    stall_cnt, flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs3, id_use_rs1, id_use_rs2, id_use_rs3,
               ex_rs1, ex_rs2, ex_rs3, ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, mem_memread, wb_rd, wb_regwrite,
               br_taken, mem_busy, clr_cnt,
        input  fwd1_sel, fwd2_sel, fwd3_sel, pc_write, ifid_write, idex_write,
               exmem_write, ifid_flush, idex_bubble, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs3, id_use_rs1, id_use_rs2, id_use_rs3,
               ex_rs1, ex_rs2, ex_rs3, ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, mem_memread, wb_rd, wb_regwrite,
               br_taken, mem_busy, clr_cnt,
        output fwd1_sel, fwd2_sel, fwd3_sel, pc_write, ifid_write, idex_write,
               exmem_write, ifid_flush, idex_bubble, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard control: operand forwarding selects, load-use/store-data stalls,
// branch flush and memory-busy freeze sequencing, saturating stall/flush counters.
module ex_hazard_ctrl #(
    parameter int REG_BITS     = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input logic             clk,
    input logic             reset,
    ex_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_FREEZE = 2'd2;
    localparam logic [3:0] REMAIN_INIT = 4'(FLUSH_CYCLES - 1);

    logic [1:0]       state_q, state_d, resume_q, resume_d, eff_state;
    logic [3:0]       remain_q, remain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             hazard_ld, hazard_st, hazard;
    logic             stall_inc, flush_inc;
    logic [1:0]       fwd1_sel, fwd2_sel;
    logic             fwd3_sel;
    logic             pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble;

    // MEM result wins over WB; a load in MEM has no data yet, so only WB can supply it.
    always_comb begin
        if (bus.ex_rs1 != '0 && bus.mem_regwrite && !bus.mem_memread && bus.mem_rd == bus.ex_rs1)
            fwd1_sel = 2'd0;
        else if (bus.ex_rs1 != '0 && bus.wb_regwrite && bus.wb_rd == bus.ex_rs1)
            fwd1_sel = 2'd1;
        else
            fwd1_sel = 2'd2;

        if (bus.ex_rs2 != '0 && bus.mem_regwrite && !bus.mem_memread && bus.mem_rd == bus.ex_rs2)
            fwd2_sel = 2'd0;
        else if (bus.ex_rs2 != '0 && bus.wb_regwrite && bus.wb_rd == bus.ex_rs2)
            fwd2_sel = 2'd1;
        else
            fwd2_sel = 2'd2;

        fwd3_sel = !(bus.ex_rs3 != '0 && bus.wb_regwrite && bus.wb_rd == bus.ex_rs3);
    end

    assign hazard_ld = bus.ex_memread && bus.ex_rd != '0 &&
                       ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
                        (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
    assign hazard_st = bus.ex_regwrite && bus.ex_rd != '0 && bus.id_use_rs3 && bus.id_rs3 == bus.ex_rd;
    assign hazard    = hazard_ld || hazard_st;

    // Leaving FREEZE applies the resume state's rules in the same cycle.
    assign eff_state = (state_q == ST_FREEZE) ? resume_q : state_q;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        resume_d    = resume_q;
        remain_d    = remain_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (bus.mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            state_d     = ST_FREEZE;
            resume_d    = eff_state;
        end else if (eff_state == ST_FLUSH) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            remain_d    = remain_q - 4'd1;
            state_d     = (remain_q == 4'd1) ? ST_RUN : ST_FLUSH;
        end else begin
            state_d = ST_RUN;
            if (bus.br_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                flush_inc   = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d  = ST_FLUSH;
                    remain_d = REMAIN_INIT;
                end
            end else if (hazard) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                stall_inc   = 1'b1;
            end
        end

        if (reset) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush_inc && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q     <= ST_RUN;
            resume_q    <= ST_RUN;
            remain_q    <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            remain_q    <= remain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.fwd1_sel    = fwd1_sel;
    assign bus.fwd2_sel    = fwd2_sel;
    assign bus.fwd3_sel    = fwd3_sel;
    assign bus.pc_write    = pc_write;
    assign bus.ifid_write  = ifid_write;
    assign bus.idex_write  = idex_write;
    assign bus.exmem_write = exmem_write;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle model built from the pipeline-control rules.
module tb_ex_hazard_ctrl;
    localparam int REG_BITS = 3;
    localparam int FC       = 3;
    localparam int CNT_W    = 10;  // narrow counters keep the saturation run short
    localparam int CMAX     = (1 << CNT_W) - 1;

    // Control vector order: {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble}
    localparam logic [5:0] C_RUN    = 6'b111100;
    localparam logic [5:0] C_FREEZE = 6'b000000;
    localparam logic [5:0] C_FLUSH  = 6'b111111;
    localparam logic [5:0] C_STALL  = 6'b001101;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int m_pend, m_stall, m_flush;

    ex_hazard_ctrl_if #(.REG_BITS(REG_BITS), .CNT_W(CNT_W)) hif ();

    ex_hazard_ctrl #(.REG_BITS(REG_BITS), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (hif)
    );

    always #5 clk = ~clk;

    logic [5:0] dut_ctrl;
    assign dut_ctrl = {hif.pc_write, hif.ifid_write, hif.idex_write, hif.exmem_write,
                       hif.ifid_flush, hif.idex_bubble};

    function automatic logic [1:0] ref_fwd(input logic [2:0] src);
        if (src != 0 && hif.mem_regwrite && !hif.mem_memread && hif.mem_rd == src) return 2'd0;
        if (src != 0 && hif.wb_regwrite && hif.wb_rd == src) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic ref_fwd3();
        return (hif.ex_rs3 != 0 && hif.wb_regwrite && hif.wb_rd == hif.ex_rs3) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic ref_hazard();
        logic ld, st;
        ld = hif.ex_memread && hif.ex_rd != 0 &&
             ((hif.id_use_rs1 && hif.id_rs1 == hif.ex_rd) || (hif.id_use_rs2 && hif.id_rs2 == hif.ex_rd));
        st = hif.ex_regwrite && hif.ex_rd != 0 && hif.id_use_rs3 && hif.id_rs3 == hif.ex_rd;
        return ld || st;
    endfunction

    // m_pend counts flush cycles still owed after the branch cycle itself.
    function automatic logic [5:0] ref_ctrl();
        if (reset)            return C_RUN;
        if (hif.mem_busy)     return C_FREEZE;
        if (m_pend > 0)       return C_FLUSH;
        if (hif.br_taken)     return C_FLUSH;
        if (ref_hazard())     return C_STALL;
        return C_RUN;
    endfunction

    task automatic model_step();
        bit st = 0, fl = 0;
        if (!hif.mem_busy) begin
            if (m_pend > 0) m_pend--;
            else if (hif.br_taken) begin m_pend = FC - 1; fl = 1; end
            else if (ref_hazard()) st = 1;
        end
        if (hif.clr_cnt) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (st && m_stall < CMAX) m_stall++;
            if (fl && m_flush < CMAX) m_flush++;
        end
    endtask

    task automatic tick();
        if (reset) begin m_pend = 0; m_stall = 0; m_flush = 0; end
        else model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hif.id_rs1 = 0; hif.id_rs2 = 0; hif.id_rs3 = 0;
        hif.id_use_rs1 = 0; hif.id_use_rs2 = 0; hif.id_use_rs3 = 0;
        hif.ex_rs1 = 0; hif.ex_rs2 = 0; hif.ex_rs3 = 0; hif.ex_rd = 0;
        hif.ex_regwrite = 0; hif.ex_memread = 0;
        hif.mem_rd = 0; hif.mem_regwrite = 0; hif.mem_memread = 0;
        hif.wb_rd = 0; hif.wb_regwrite = 0;
        hif.br_taken = 0; hif.mem_busy = 0; hif.clr_cnt = 0;
    endtask

    task automatic set_load_use();
        hif.ex_memread = 1; hif.ex_rd = 3; hif.id_rs1 = 3; hif.id_use_rs1 = 1;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        m_pend = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic rand_inputs();
        hif.id_rs1 = 3'($urandom_range(0, 7)); hif.id_rs2 = 3'($urandom_range(0, 7));
        hif.id_rs3 = 3'($urandom_range(0, 7));
        hif.id_use_rs1 = 1'($urandom); hif.id_use_rs2 = 1'($urandom); hif.id_use_rs3 = 1'($urandom);
        hif.ex_rs1 = 3'($urandom_range(0, 7)); hif.ex_rs2 = 3'($urandom_range(0, 7));
        hif.ex_rs3 = 3'($urandom_range(0, 7)); hif.ex_rd = 3'($urandom_range(0, 7));
        hif.ex_regwrite = 1'($urandom); hif.ex_memread = 1'($urandom);
        hif.mem_rd = 3'($urandom_range(0, 7));
        hif.mem_regwrite = 1'($urandom); hif.mem_memread = 1'($urandom);
        hif.wb_rd = 3'($urandom_range(0, 7)); hif.wb_regwrite = 1'($urandom);
        hif.br_taken = ($urandom_range(0, 9) == 0);
        hif.mem_busy = ($urandom_range(0, 7) == 0);
        hif.clr_cnt  = ($urandom_range(0, 63) == 0);
    endtask

    task automatic test_reset();
        idle();
        hif.ex_rs1 = 5; hif.wb_regwrite = 1; hif.wb_rd = 5;
        reset = 1;
        #3;
        checks++;
        if (dut_ctrl !== C_RUN || hif.stall_cnt !== '0 || hif.flush_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state ctrl=%b stall=%0d flush=%0d, want ctrl=%b counters 0",
                     dut_ctrl, hif.stall_cnt, hif.flush_cnt, C_RUN);
        end
        checks++;
        if (hif.fwd1_sel !== 2'd1) begin
            errors++;
            $display("FAIL reset_fwd fwd1_sel=%0d want 1", hif.fwd1_sel);
        end
        tick();
        apply_reset();
    endtask

    task automatic test_load_use();
        apply_reset();
        set_load_use();
        #3;
        checks++;
        if (dut_ctrl !== C_STALL) begin
            errors++;
            $display("FAIL load_use_stall ctrl=%b want %b", dut_ctrl, C_STALL);
        end
        tick();
        hif.ex_memread = 0; hif.ex_rd = 0;
        #3;
        checks++;
        if (dut_ctrl !== C_RUN || hif.stall_cnt !== CNT_W'(1)) begin
            errors++;
            $display("FAIL load_use_release ctrl=%b stall=%0d want ctrl=%b stall=1",
                     dut_ctrl, hif.stall_cnt, C_RUN);
        end
        // Store-data hazard: ALU result in EX needed as store data by ID.
        hif.ex_regwrite = 1; hif.ex_rd = 4; hif.id_rs3 = 4; hif.id_use_rs3 = 1;
        #1;
        checks++;
        if (dut_ctrl !== C_STALL) begin
            errors++;
            $display("FAIL store_data_stall ctrl=%b want %b", dut_ctrl, C_STALL);
        end
        tick();
        idle();
    endtask

    task automatic test_forwarding();
        logic [1:0] exp_sel [3] = '{2'd0, 2'd1, 2'd2};
        idle();
        hif.ex_rs1 = 2; hif.mem_regwrite = 1; hif.mem_rd = 2; hif.wb_regwrite = 1; hif.wb_rd = 2;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) hif.mem_memread = 1;
            if (i == 2) hif.ex_rs1 = 0;
            #1;
            checks++;
            if (hif.fwd1_sel !== exp_sel[i]) begin
                errors++;
                $display("FAIL fwd1_step%0d fwd1_sel=%0d want %0d", i, hif.fwd1_sel, exp_sel[i]);
            end
        end
        for (int i = 0; i < 200; i++) begin
            rand_inputs();
            hif.mem_busy = 1;
            #1;
            checks++;
            if (hif.fwd1_sel !== ref_fwd(hif.ex_rs1) || hif.fwd2_sel !== ref_fwd(hif.ex_rs2) ||
                hif.fwd3_sel !== ref_fwd3()) begin
                errors++;
                $display("FAIL fwd_random fwd=%0d/%0d/%0d want %0d/%0d/%0d", hif.fwd1_sel, hif.fwd2_sel,
                         hif.fwd3_sel, ref_fwd(hif.ex_rs1), ref_fwd(hif.ex_rs2), ref_fwd3());
            end
        end
        apply_reset();
    endtask

    task automatic test_flush();
        logic       br  [5] = '{1, 0, 1, 0, 0};
        logic [5:0] exp [5] = '{C_FLUSH, C_FLUSH, C_FLUSH, C_RUN, C_RUN};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            hif.br_taken = br[i];
            #3;
            checks++;
            if (dut_ctrl !== exp[i]) begin
                errors++;
                $display("FAIL flush_cycle%0d ctrl=%b want %b", i, dut_ctrl, exp[i]);
            end
            tick();
        end
        checks++;
        if (hif.flush_cnt !== CNT_W'(1)) begin
            errors++;
            $display("FAIL flush_count flush_cnt=%0d want 1", hif.flush_cnt);
        end
        idle();
    endtask

    task automatic test_branch_hazard();
        apply_reset();
        set_load_use();
        hif.br_taken = 1;
        #3;
        checks++;
        if (dut_ctrl !== C_FLUSH) begin
            errors++;
            $display("FAIL br_vs_hazard ctrl=%b want %b", dut_ctrl, C_FLUSH);
        end
        tick();
        checks++;
        if (hif.stall_cnt !== '0 || hif.flush_cnt !== CNT_W'(1)) begin
            errors++;
            $display("FAIL br_vs_hazard_cnt stall=%0d flush=%0d want 0 and 1", hif.stall_cnt, hif.flush_cnt);
        end
        idle();
        for (int i = 0; i < FC; i++) tick();
    endtask

    task automatic test_flush_freeze();
        logic [5:0] exp [9] = '{C_FLUSH, C_FLUSH, C_FREEZE, C_FREEZE, C_FREEZE, C_FREEZE,
                                C_FLUSH, C_RUN, C_RUN};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            hif.br_taken = (i == 0);
            hif.mem_busy = (i >= 2 && i <= 5);
            if (i == 3) set_load_use();
            #3;
            checks++;
            if (dut_ctrl !== exp[i]) begin
                errors++;
                $display("FAIL flush_freeze_cycle%0d ctrl=%b want %b", i, dut_ctrl, exp[i]);
            end
            tick();
            if (i == 3) idle();
        end
        checks++;
        if (hif.flush_cnt !== CNT_W'(1) || hif.stall_cnt !== '0) begin
            errors++;
            $display("FAIL freeze_counters flush=%0d stall=%0d want 1 and 0", hif.flush_cnt, hif.stall_cnt);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        set_load_use();
        for (int i = 0; i < CMAX + 8; i++) tick();
        checks++;
        if (hif.stall_cnt !== CNT_W'(CMAX)) begin
            errors++;
            $display("FAIL stall_saturate stall_cnt=%0d want %0d", hif.stall_cnt, CMAX);
        end
        hif.clr_cnt = 1;
        tick();
        hif.clr_cnt = 0;
        checks++;
        if (hif.stall_cnt !== '0) begin
            errors++;
            $display("FAIL clr_over_inc stall_cnt=%0d want 0", hif.stall_cnt);
        end
        hif.mem_busy = 1;
        tick();
        tick();
        #2;
        checks++;
        if (dut_ctrl !== C_FREEZE) begin
            errors++;
            $display("FAIL frozen ctrl=%b want %b", dut_ctrl, C_FREEZE);
        end
        reset = 1;
        #1;
        checks++;
        if (dut_ctrl !== C_RUN || hif.stall_cnt !== '0) begin
            errors++;
            $display("FAIL reset_mid_freeze ctrl=%b stall=%0d want %b and 0", dut_ctrl, hif.stall_cnt, C_RUN);
        end
        tick();
        reset = 0;
        idle();
        m_pend = 0; m_stall = 0; m_flush = 0;
        #2;
        checks++;
        if (dut_ctrl !== C_RUN) begin
            errors++;
            $display("FAIL after_reset_run ctrl=%b want %b", dut_ctrl, C_RUN);
        end
    endtask

    task automatic test_random();
        logic [5:0] exp;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            #3;
            exp = ref_ctrl();
            checks++;
            if (dut_ctrl !== exp || hif.stall_cnt !== CNT_W'(m_stall) || hif.flush_cnt !== CNT_W'(m_flush)) begin
                errors++;
                $display("FAIL random_cycle%0d ctrl=%b stall=%0d flush=%0d want ctrl=%b stall=%0d flush=%0d",
                         i, dut_ctrl, hif.stall_cnt, hif.flush_cnt, exp, m_stall, m_flush);
            end
            checks++;
            if (hif.fwd1_sel !== ref_fwd(hif.ex_rs1) || hif.fwd2_sel !== ref_fwd(hif.ex_rs2) ||
                hif.fwd3_sel !== ref_fwd3()) begin
                errors++;
                $display("FAIL random_fwd%0d fwd=%0d/%0d/%0d want %0d/%0d/%0d", i, hif.fwd1_sel,
                         hif.fwd2_sel, hif.fwd3_sel, ref_fwd(hif.ex_rs1), ref_fwd(hif.ex_rs2), ref_fwd3());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        m_pend = 0; m_stall = 0; m_flush = 0;
        idle();
        test_reset();
        test_load_use();
        test_forwarding();
        test_flush();
        test_branch_hazard();
        test_flush_freeze();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
